// File: rtl/uart_pkg.sv
// Shared constants for the UART peripheral: 8N1 bit count and the TX/RX FSM encodings.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  localparam logic [1:0] UART_TX_IDLE  = 2'd0;
  localparam logic [1:0] UART_TX_START = 2'd1;
  localparam logic [1:0] UART_TX_DATA  = 2'd2;
  localparam logic [1:0] UART_TX_STOP  = 2'd3;

  localparam logic [1:0] UART_RX_IDLE  = 2'd0;
  localparam logic [1:0] UART_RX_START = 2'd1;
  localparam logic [1:0] UART_RX_DATA  = 2'd2;
  localparam logic [1:0] UART_RX_STOP  = 2'd3;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO. A push into a full FIFO is accepted only if the head
// is popped in the same cycle; otherwise the byte is dropped and 'drop' pulses.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop_req,
  output logic [7:0] head_data,
  output logic       not_empty,
  output logic       drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CNTW-1:0] count;
  logic            full;
  logic            pop;
  logic            push_ok;

  assign full      = (count == FULL_CNT);
  assign not_empty = (count != '0);
  assign pop       = pop_req && not_empty;
  assign push_ok   = push && (!full || pop);
  assign drop      = push && full && !pop;
  // Gated so the head reads zero whenever the FIFO is empty, including reset.
  assign head_data = not_empty ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push_ok) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_peripheral.sv
// 8N1 UART with independent TX and RX state machines, each with its own baud
// counter, and a show-ahead receive FIFO. FSM states are exported for observation.
module uart_peripheral
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 868,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_we,
  output logic       tx_busy,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_re,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  output logic       uart_txd,
  input  logic       uart_rxd,
  output logic [1:0] tx_state,
  output logic [1:0] rx_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(UART_DATA_BITS - 1);

  // ---------------- transmitter ----------------
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_byte;

  assign tx_busy = (tx_state != UART_TX_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= UART_TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_byte  <= '0;
      uart_txd <= 1'b1;
    end else begin
      case (tx_state)
        UART_TX_IDLE: begin
          uart_txd <= 1'b1;
          if (tx_we) begin
            tx_byte  <= tx_data;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            uart_txd <= 1'b0;
            tx_state <= UART_TX_START;
          end
        end
        UART_TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            uart_txd <= tx_byte[0];
            tx_state <= UART_TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        UART_TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_idx == IDX_LAST) begin
              uart_txd <= 1'b1;
              tx_state <= UART_TX_STOP;
            end else begin
              tx_idx   <= tx_idx + 3'd1;
              uart_txd <= tx_byte[tx_idx + 3'd1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_state <= UART_TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------- receiver ----------------
  // Synchronizer and edge-detect flops preset to the idle level so reset never fakes a start.
  logic [1:0]    rxd_sync;
  logic          rxd_s;
  logic          rxd_prev;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_shift;
  logic          rx_push;
  logic          fifo_drop;

  assign rxd_s   = rxd_sync[1];
  assign rx_push = (rx_state == UART_RX_STOP) && (rx_cnt == BIT_LAST) && rxd_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_sync <= 2'b11;
      rxd_prev <= 1'b1;
    end else begin
      rxd_sync <= {rxd_sync[0], uart_rxd};
      rxd_prev <= rxd_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state     <= UART_RX_IDLE;
      rx_cnt       <= '0;
      rx_idx       <= '0;
      rx_shift     <= '0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      if (fifo_drop) begin
        rx_overrun <= 1'b1;
      end
      case (rx_state)
        UART_RX_IDLE: begin
          if (rxd_prev && !rxd_s) begin
            rx_cnt   <= '0;
            rx_state <= UART_RX_START;
          end
        end
        UART_RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt <= '0;
            rx_idx <= '0;
            rx_state <= rxd_s ? UART_RX_IDLE : UART_RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        UART_RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rxd_s, rx_shift[7:1]};
            if (rx_idx == IDX_LAST) begin
              rx_state <= UART_RX_STOP;
            end else begin
              rx_idx <= rx_idx + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= UART_RX_IDLE;
            if (!rxd_s) begin
              rx_frame_err <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  uart_rx_fifo #(
    .DEPTH(RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (rx_push),
    .push_data(rx_shift),
    .pop_req  (rx_re),
    .head_data(rx_data),
    .not_empty(rx_valid),
    .drop     (fifo_drop)
  );

endmodule
